// File: rtl/song_tutor_ctrl_pkg.sv
// Shared piano constants: note codes, LED patterns and the tutor controller state encoding.
package song_tutor_ctrl_pkg;

  localparam logic [3:0] NOTE_NONE = 4'd0;
  localparam logic [3:0] NOTE_C    = 4'd1;
  localparam logic [3:0] NOTE_D    = 4'd3;
  localparam logic [3:0] NOTE_E    = 4'd5;
  localparam logic [3:0] NOTE_F    = 4'd6;
  localparam logic [3:0] NOTE_G    = 4'd8;
  localparam logic [3:0] NOTE_A    = 4'd10;
  localparam logic [3:0] NOTE_B    = 4'd12;

  localparam logic [7:0] LED_OFF    = 8'h00;
  localparam logic [7:0] LED_ALL_ON = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hint_timer.sv
// Idle timer that saturates at TIMEOUT_CYCLES, then blinks a blank request
// with a half-period of BLINK_HALF cycles, starting blanked.
module hint_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter int unsigned BLINK_HALF     = 25000000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic blank
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_HALF - 1);

  logic [TW-1:0] timer_q;
  logic [BW-1:0] bcnt_q;
  logic          phase_q;
  logic          sat;

  assign sat   = (timer_q == TMAX);
  assign blank = sat && !phase_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      timer_q <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      if (clear) begin
        timer_q <= '0;
      end else if (enable && !sat) begin
        timer_q <= timer_q + 1'b1;
      end
      // Blink state only runs while saturated so every hint starts blanked.
      if (clear || !sat) begin
        bcnt_q  <= '0;
        phase_q <= 1'b0;
      end else if (enable) begin
        if (bcnt_q == BLAST) begin
          bcnt_q  <= '0;
          phase_q <= ~phase_q;
        end else begin
          bcnt_q <= bcnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/song_tutor_ctrl.sv
// Piano song-tutor session controller: selects one of four tutors, counts presses,
// and blinks the hint LEDs after a period of player inactivity.
module song_tutor_ctrl
  import song_tutor_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter int unsigned BLINK_HALF     = 25000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] note,
  input  logic [1:0] song_sel,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] tutor_led0,
  input  logic [7:0] tutor_led1,
  input  logic [7:0] tutor_led2,
  input  logic [7:0] tutor_led3,
  input  logic [3:0] tutor_done,
  output logic [3:0] tutor_rst,
  output logic [3:0] note_q,
  output logic [7:0] Led,
  output logic [7:0] presses,
  output logic       busy,
  output logic       done
);

  state_t     state_q, state_d;
  logic [1:0] sel_q;
  logic       take_start;
  logic       done_d;
  logic       press_edge;
  logic       blank;
  logic [7:0] led_sel;

  assign press_edge = (note_q == NOTE_NONE) && (note != NOTE_NONE);

  hint_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .BLINK_HALF    (BLINK_HALF)
  ) u_hint_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .clear ((note != note_q) || (state_q != RUN)),
    .enable(state_q == RUN),
    .blank (blank)
  );

  always_comb begin
    unique case (sel_q)
      2'd0: led_sel = tutor_led0;
      2'd1: led_sel = tutor_led1;
      2'd2: led_sel = tutor_led2;
      2'd3: led_sel = tutor_led3;
    endcase
  end

  // Priority abort > start > tutor_done; start is ignored while running.
  always_comb begin
    state_d    = state_q;
    take_start = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!abort && start) begin
          state_d    = RUN;
          take_start = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tutor_done[sel_q]) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d    = RUN;
          take_start = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tutor_rst = 4'b1111;
    Led       = LED_OFF;
    busy      = 1'b0;
    unique case (state_q)
      RUN: begin
        tutor_rst[sel_q] = 1'b0;
        Led              = blank ? LED_OFF : led_sel;
        busy             = 1'b1;
      end
      DONE:    Led = LED_ALL_ON;
      default: Led = LED_OFF;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      note_q  <= NOTE_NONE;
      presses <= 8'h00;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note;
      done    <= done_d;
      if (take_start) begin
        sel_q   <= song_sel;
        presses <= 8'h00;
      end else if ((state_q == RUN) && press_edge && (presses != 8'hFF)) begin
        presses <= presses + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_song_tutor_ctrl.sv
// Directed bench for song_tutor_ctrl with a small expected-value scoreboard.
module tb_song_tutor_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] note = 4'd0;
  logic [1:0] song_sel = 2'd0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] tutor_led0 = 8'h11;
  logic [7:0] tutor_led1 = 8'h22;
  logic [7:0] tutor_led2 = 8'h5A;
  logic [7:0] tutor_led3 = 8'h81;
  logic [3:0] tutor_done = 4'd0;
  logic [3:0] tutor_rst;
  logic [3:0] note_q;
  logic [7:0] Led;
  logic [7:0] presses;
  logic       busy;
  logic       done;

  song_tutor_ctrl #(
    .TIMEOUT_CYCLES(8),
    .BLINK_HALF    (2)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .note      (note),
    .song_sel  (song_sel),
    .start     (start),
    .abort     (abort),
    .tutor_led0(tutor_led0),
    .tutor_led1(tutor_led1),
    .tutor_led2(tutor_led2),
    .tutor_led3(tutor_led3),
    .tutor_done(tutor_done),
    .tutor_rst (tutor_rst),
    .note_q    (note_q),
    .Led       (Led),
    .presses   (presses),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic exp_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: got %0h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: got %0h required %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [7:0] exp_led;

    // Asynchronous reset before any clock edge.
    RESET = 1'b0;
    #1 RESET = 1'b1;
    #1;
    exp_push("rst_busy", 0);      chk(busy);
    exp_push("rst_trst", 4'hF);   chk(tutor_rst);
    exp_push("rst_led", 8'h00);   chk(Led);
    exp_push("rst_presses", 0);   chk(presses);
    exp_push("rst_done", 0);      chk(done);
    exp_push("rst_noteq", 0);     chk(note_q);
    tick();
    tick();
    RESET = 1'b0;
    tick();

    // Start song 2.
    song_sel = 2'd2;
    start    = 1'b1;
    exp_push("start_busy", 1);
    exp_push("start_trst", 4'b1011);
    exp_push("start_presses", 0);
    exp_push("start_led", 8'h5A);
    tick();
    start    = 1'b0;
    song_sel = 2'd3;
    chk(busy);
    chk(tutor_rst);
    chk(presses);
    chk(Led);

    // Five press/release cycles of note 3.
    for (int i = 0; i < 5; i++) begin
      note = 4'd3;
      exp_push("noteq_lag", 0);
      chk(note_q);
      exp_push("noteq_follow", 3);
      exp_push("press_count", i + 1);
      tick();
      chk(note_q);
      chk(presses);
      note = 4'd0;
      tick();
    end
    exp_push("presses_5", 5);
    chk(presses);

    // Idle hint: steady for 8 cycles, then 00/5A toggling every 2 cycles.
    for (int i = 0; i <= 16; i++) begin
      if (i < 8) exp_led = 8'h5A;
      else if ((((i - 8) / 2) % 2) == 0) exp_led = 8'h00;
      else exp_led = 8'h5A;
      exp_push("blink_led", {24'd0, exp_led});
      chk(Led);
      if (i < 16) tick();
    end
    note = 4'd5;
    exp_push("restore_led", 8'h5A);
    exp_push("restore_presses", 6);
    tick();
    chk(Led);
    chk(presses);

    // Completion from a non-selected tutor is ignored.
    tutor_done = 4'b0001;
    exp_push("other_done_busy", 1);
    exp_push("other_done_done", 0);
    tick();
    tutor_done = 4'b0000;
    chk(busy);
    chk(done);

    // Completion from the selected tutor.
    tutor_done = 4'b0100;
    exp_push("done_pulse", 1);
    exp_push("done_led", 8'hFF);
    exp_push("done_trst", 4'hF);
    exp_push("done_busy", 0);
    tick();
    tutor_done = 4'b0000;
    chk(done);
    chk(Led);
    chk(tutor_rst);
    chk(busy);
    exp_push("done_single", 0);
    exp_push("done_led_hold", 8'hFF);
    note = 4'd0;
    tick();
    chk(done);
    chk(Led);
    note = 4'd7;
    exp_push("done_frozen", 6);
    tick();
    chk(presses);

    // New session from DONE with song 1.
    song_sel = 2'd1;
    start    = 1'b1;
    exp_push("restart_trst", 4'b1101);
    exp_push("restart_presses", 0);
    exp_push("restart_led", 8'h22);
    tick();
    start = 1'b0;
    chk(tutor_rst);
    chk(presses);
    chk(Led);

    // Abort and start together in RUN.
    abort = 1'b1;
    start = 1'b1;
    exp_push("abort_busy", 0);
    exp_push("abort_led", 8'h00);
    exp_push("abort_trst", 4'hF);
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk(busy);
    chk(Led);
    chk(tutor_rst);

    // Press saturation on song 0.
    song_sel = 2'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    note  = 4'd0;
    tick();
    for (int i = 0; i < 300; i++) begin
      note = 4'd1;
      tick();
      note = 4'd0;
      tick();
    end
    exp_push("presses_sat", 8'hFF);
    chk(presses);

    // Asynchronous reset between edges.
    #2 RESET = 1'b1;
    #1;
    exp_push("mid_rst_busy", 0);     chk(busy);
    exp_push("mid_rst_trst", 4'hF);  chk(tutor_rst);
    exp_push("mid_rst_led", 8'h00);  chk(Led);
    exp_push("mid_rst_presses", 0);  chk(presses);
    exp_push("mid_rst_done", 0);     chk(done);
    tutor_done = 4'b0001;
    tick();
    tick();
    RESET      = 1'b0;
    tutor_done = 4'b0000;
    exp_push("post_rst_done", 0);
    exp_push("post_rst_busy", 0);
    tick();
    chk(done);
    chk(busy);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
